// File: rtl/accu_axil_pkg.sv
// Shared constants for the accu_ip AXI4-Lite register slave.
// Holds the register map offsets, the response code, the CTRL and STATUS bit
// positions, and a helper that expands byte strobes into a bit mask.
package accu_axil_pkg;

   localparam int unsigned AXI_DATA_W = 32;
   localparam int unsigned AXI_ADDR_W = 5;
   localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;

   // Byte offsets of the word registers; bits [4:2] select the word
   localparam logic [AXI_ADDR_W-1:0] ADDR_REG0    = 5'h00;
   localparam logic [AXI_ADDR_W-1:0] ADDR_REG1    = 5'h04;
   localparam logic [AXI_ADDR_W-1:0] ADDR_REG2    = 5'h08;
   localparam logic [AXI_ADDR_W-1:0] ADDR_REG3    = 5'h0C;
   localparam logic [AXI_ADDR_W-1:0] ADDR_ACC_IN  = 5'h10;
   localparam logic [AXI_ADDR_W-1:0] ADDR_ACC_OUT = 5'h14;
   localparam logic [AXI_ADDR_W-1:0] ADDR_CTRL    = 5'h18;
   localparam logic [AXI_ADDR_W-1:0] ADDR_STATUS  = 5'h1C;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   localparam int unsigned CTRL_CLR_BIT   = 0;
   localparam int unsigned STATUS_OVF_BIT = 0;
   localparam int unsigned STATUS_CNT_LSB = 16;
   localparam int unsigned STATUS_CNT_W   = 16;

   // Expand per-byte strobes into a per-bit mask
   function automatic logic [AXI_DATA_W-1:0] strb_mask(input logic [AXI_STRB_W-1:0] strb);
      logic [AXI_DATA_W-1:0] m;
      m = '0;
      for (int b = 0; b < int'(AXI_STRB_W); b++) begin
         m[b*8 +: 8] = {8{strb[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/accu_core.sv
// Unsigned accumulator with sticky carry-out flag and saturating event counter.
// Ports: clk, rst_n (async active-low); add_en/add_data add one operand;
//        clr zeroes acc, ovf and cnt (wins over add_en); acc, ovf, cnt are
//        the registered state.
module accu_core #(
   parameter int unsigned ACC_W = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             add_en,
   input  logic [ACC_W-1:0] add_data,
   input  logic             clr,
   output logic [ACC_W-1:0] acc,
   output logic             ovf,
   output logic [CNT_W-1:0] cnt
);

   logic [ACC_W:0] sum;

   // One extra bit captures the carry out of the modular add
   assign sum = {1'b0, acc} + {1'b0, add_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         ovf <= 1'b0;
         cnt <= '0;
      end else if (clr) begin
         acc <= '0;
         ovf <= 1'b0;
         cnt <= '0;
      end else if (add_en) begin
         acc <= sum[ACC_W-1:0];
         if (sum[ACC_W]) ovf <= 1'b1;
         if (cnt != '1) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/accu_axil_slave.sv
// AXI4-Lite slave of accu_ip: four RW scratch registers plus an accumulator
// (ACC_IN add, ACC_OUT read, CTRL clear, STATUS count/overflow).
// Ports: S_AXI_* AXI4-Lite slave channels on S_AXI_ACLK with async active-low
//        S_AXI_ARESETN; acc_out / acc_ovf mirror the accumulator state.
module accu_axil_slave
   import accu_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned C_CNT_WIDTH        = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   acc_out,
   output logic                            acc_ovf
);

   logic                          wr_fire;
   logic                          rd_fire;
   logic [2:0]                    wr_idx;
   logic [2:0]                    rd_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0] wmask;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_m;
   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];
   logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;
   logic [C_S_AXI_DATA_WIDTH-1:0] status_word;
   logic [C_S_AXI_DATA_WIDTH-1:0] acc;
   logic                          ovf;
   logic [C_CNT_WIDTH-1:0]        cnt;
   logic                          add_en;
   logic                          clr;
   logic                          unused_c;

   // Protection bits and the byte lane of the address carry no meaning here
   assign unused_c = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_fire = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WREADY & S_AXI_WVALID;
   assign rd_fire = S_AXI_ARREADY & S_AXI_ARVALID;
   assign wr_idx  = S_AXI_AWADDR[4:2];
   assign rd_idx  = S_AXI_ARADDR[4:2];
   assign wmask   = strb_mask(S_AXI_WSTRB);
   assign wdata_m = S_AXI_WDATA & wmask;

   assign S_AXI_BRESP = RESP_OKAY;
   assign S_AXI_RRESP = RESP_OKAY;

   // Write channel: AW and W accepted together, one response outstanding
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
      end else begin
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         if (!S_AXI_AWREADY && !S_AXI_BVALID && S_AXI_AWVALID && S_AXI_WVALID) begin
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
         end
         if (wr_fire) begin
            S_AXI_BVALID <= 1'b1;
         end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
         end
      end
   end

   // Scratch registers with byte-lane writes
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         for (int i = 0; i < 4; i++) regs[i] <= '0;
      end else if (wr_fire) begin
         for (int i = 0; i < 4; i++) begin
            if (wr_idx == 3'(i)) regs[i] <= (regs[i] & ~wmask) | wdata_m;
         end
      end
   end

   assign add_en = wr_fire && (wr_idx == ADDR_ACC_IN[4:2]);
   assign clr    = wr_fire && (wr_idx == ADDR_CTRL[4:2]) && wdata_m[CTRL_CLR_BIT];

   accu_core #(
      .ACC_W (C_S_AXI_DATA_WIDTH),
      .CNT_W (C_CNT_WIDTH)
   ) u_core (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .add_en   (add_en),
      .add_data (wdata_m),
      .clr      (clr),
      .acc      (acc),
      .ovf      (ovf),
      .cnt      (cnt)
   );

   assign acc_out = acc;
   assign acc_ovf = ovf;

   // Read-side decode of the register map
   always_comb begin
      status_word = '0;
      status_word[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(cnt);
      status_word[STATUS_OVF_BIT] = ovf;
      rd_word = '0;
      case (rd_idx)
         ADDR_REG0[4:2], ADDR_REG1[4:2],
         ADDR_REG2[4:2], ADDR_REG3[4:2]: rd_word = regs[rd_idx[1:0]];
         ADDR_ACC_OUT[4:2]:              rd_word = acc;
         ADDR_STATUS[4:2]:               rd_word = status_word;
         default:                        rd_word = '0;
      endcase
   end

   // Read channel: data captured on the address handshake, held until RREADY
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
      end else begin
         S_AXI_ARREADY <= 1'b0;
         if (!S_AXI_ARREADY && !S_AXI_RVALID && S_AXI_ARVALID) begin
            S_AXI_ARREADY <= 1'b1;
         end
         if (rd_fire) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_word;
         end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
         end
      end
   end

endmodule
